alu_acumulador_param: RTL and testbench



---
 rtl/alu_acumulador_param_pkg.sv | 18 +
 rtl/alu_acumulador_param_sumador_restador_n.sv | 28 ++
 rtl/alu_acumulador_param.sv | 119 +++++++++++
 tb/tb_alu_acumulador_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_acumulador_param_pkg.sv
// Shared definitions for the accumulating add/subtract stage: operation
// encodings carried on MODO and its width.
package alu_acumulador_param_pkg;

  localparam int MODO_WIDTH = 3;

  typedef enum logic [MODO_WIDTH-1:0] {
    MODO_HOLD = 3'b000,
    MODO_ADD  = 3'b001,
    MODO_SUB  = 3'b010,
    MODO_CLR  = 3'b011,
    MODO_ACC  = 3'b100,
    MODO_DACC = 3'b101,
    MODO_INC  = 3'b110,
    MODO_RSVD = 3'b111
  } modo_t;

endpackage

// File: rtl/alu_acumulador_param_sumador_restador_n.sv
// Combinational WIDTH-bit adder/subtractor. cout is the carry when adding
// and the borrow (a < b + cin) when subtracting.
module sumador_restador_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] ext;

  // One extra bit: for subtraction it goes to 1 exactly when the result is negative.
  always_comb begin
    if (sub) begin
      ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    end else begin
      ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end
  end

  assign s    = ext[WIDTH-1:0];
  assign cout = ext[WIDTH];

endmodule

// File: rtl/alu_acumulador_param.sv
// Registered add/subtract stage with accumulator, optional saturation, sticky
// overflow and a result-valid strobe. RCO is registered, so cascaded stages see one cycle of skew.
module alu_acumulador_param
  import alu_acumulador_param_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENB,
  input  logic                  RCI,
  input  logic [MODO_WIDTH-1:0] MODO,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  output logic [WIDTH-1:0]      Q,
  output logic                  RCO,
  output logic                  OVF,
  output logic                  VALID
);

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             op_c;
  logic             op_sub;
  logic             is_arith;
  logic             is_clr;
  logic [WIDTH-1:0] sum_s;
  logic             sum_co;
  logic [WIDTH-1:0] res;

  // Operand selection: direct modes use A/B, accumulate modes use Q with A or 1.
  always_comb begin
    op_x     = Q;
    op_y     = A;
    op_c     = RCI;
    op_sub   = 1'b0;
    is_arith = 1'b0;
    is_clr   = 1'b0;
    case (MODO)
      MODO_ADD: begin
        op_x     = A;
        op_y     = B;
        is_arith = 1'b1;
      end
      MODO_SUB: begin
        op_x     = A;
        op_y     = B;
        op_sub   = 1'b1;
        is_arith = 1'b1;
      end
      MODO_CLR: begin
        is_clr = 1'b1;
      end
      MODO_ACC: begin
        is_arith = 1'b1;
      end
      MODO_DACC: begin
        op_sub   = 1'b1;
        is_arith = 1'b1;
      end
      MODO_INC: begin
        op_y     = {{(WIDTH-1){1'b0}}, 1'b1};
        op_c     = 1'b0;
        is_arith = 1'b1;
      end
      default: begin
        is_arith = 1'b0;
      end
    endcase
  end

  sumador_restador_n #(
    .WIDTH(WIDTH)
  ) u_sumador_restador (
    .a    (op_x),
    .b    (op_y),
    .cin  (op_c),
    .sub  (op_sub),
    .s    (sum_s),
    .cout (sum_co)
  );

  // Saturation clamps toward the side the overflow happened on.
  always_comb begin
    if (SATURATE && sum_co) begin
      res = op_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      res = sum_s;
    end
  end

  // Result, carry, sticky overflow and valid strobe registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q     <= {WIDTH{1'b0}};
      RCO   <= 1'b0;
      OVF   <= 1'b0;
      VALID <= 1'b0;
    end else if (ENB) begin
      if (is_clr) begin
        Q     <= {WIDTH{1'b0}};
        RCO   <= 1'b0;
        OVF   <= 1'b0;
        VALID <= 1'b0;
      end else if (is_arith) begin
        Q     <= res;
        RCO   <= sum_co;
        OVF   <= OVF | sum_co;
        VALID <= 1'b1;
      end else begin
        VALID <= 1'b0;
      end
    end else begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_acumulador_param.sv
// Scoreboard bench for alu_acumulador_param: 8-bit wrapping and saturating
// instances driven in lockstep, plus a 4-bit instance for the increment wrap.
module tb_alu_acumulador_param;

  typedef struct {
    int          dut;
    logic [10:0] exp;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb8 = 1'b1, rci8 = 1'b0, enb4 = 1'b1, rci4 = 1'b0;
  logic [2:0] modo8 = 3'b000, modo4 = 3'b000;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic [3:0] a4 = 4'd0, b4 = 4'd0;
  logic [7:0] q8w, q8s;
  logic [3:0] q4;
  logic       rco8w, ovf8w, val8w, rco8s, ovf8s, val8s, rco4, ovf4, val4;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_acumulador_param #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
    .CLK(clk), .RST(rst), .ENB(enb8), .RCI(rci8), .MODO(modo8), .A(a8), .B(b8),
    .Q(q8w), .RCO(rco8w), .OVF(ovf8w), .VALID(val8w));

  alu_acumulador_param #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
    .CLK(clk), .RST(rst), .ENB(enb8), .RCI(rci8), .MODO(modo8), .A(a8), .B(b8),
    .Q(q8s), .RCO(rco8s), .OVF(ovf8s), .VALID(val8s));

  alu_acumulador_param #(.WIDTH(4), .SATURATE(1'b0)) dut_4 (
    .CLK(clk), .RST(rst), .ENB(enb4), .RCI(rci4), .MODO(modo4), .A(a4), .B(b4),
    .Q(q4), .RCO(rco4), .OVF(ovf4), .VALID(val4));

  function automatic logic [10:0] ex(input logic [7:0] q, input logic r, input logic o,
                                     input logic v);
    return {q, r, o, v};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got Q=%0d RCO=%b OVF=%b VALID=%b, expected Q=%0d RCO=%b OVF=%b VALID=%b",
               name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [10:0] actual(input int d);
    case (d)
      0:       return {q8w, rco8w, ovf8w, val8w};
      1:       return {q8s, rco8s, ovf8s, val8s};
      default: return {4'd0, q4, rco4, ovf4, val4};
    endcase
  endfunction

  // Monitor: after every rising edge, compare each pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, actual(e.dut), e.exp);
      end
    end
  end

  task automatic step8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic rci, input logic enb, input logic [10:0] ew,
                       input logic [10:0] es, input string name);
    @(negedge clk);
    modo8 = m; a8 = a; b8 = b; rci8 = rci; enb8 = enb;
    sb.push_back('{0, ew, {name, "_wrap"}});
    sb.push_back('{1, es, {name, "_sat"}});
  endtask

  task automatic step4(input logic [2:0] m, input logic rci, input logic [10:0] e,
                       input string name);
    @(negedge clk);
    modo4 = m; rci4 = rci; enb4 = 1'b1;
    sb.push_back('{2, e, name});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_w", actual(0), ex(8'd0, 1'b0, 1'b0, 1'b0));
    check("reset_4", actual(2), ex(8'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    // Asynchronous reset between edges.
    step8(3'b001, 8'd40, 8'd2, 1'b0, 1'b1, ex(8'd42, 1'b0, 1'b0, 1'b1),
          ex(8'd42, 1'b0, 1'b0, 1'b1), "load42");
    @(negedge clk);
    modo8 = 3'b000;
    rst = 1'b1;
    #1;
    check("async_rst_w", actual(0), ex(8'd0, 1'b0, 1'b0, 1'b0));
    check("async_rst_s", actual(1), ex(8'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("rst_held_w", actual(0), ex(8'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // ADD / SUB with wrap and saturation.
    step8(3'b001, 8'd17, 8'd3, 1'b0, 1'b1, ex(8'd20, 1'b0, 1'b0, 1'b1),
          ex(8'd20, 1'b0, 1'b0, 1'b1), "add17_3");
    step8(3'b001, 8'd255, 8'd1, 1'b0, 1'b1, ex(8'd0, 1'b1, 1'b1, 1'b1),
          ex(8'd255, 1'b1, 1'b1, 1'b1), "add255_1");
    step8(3'b011, 8'd0, 8'd0, 1'b0, 1'b1, ex(8'd0, 1'b0, 1'b0, 1'b0),
          ex(8'd0, 1'b0, 1'b0, 1'b0), "clr1");
    step8(3'b010, 8'd4, 8'd3, 1'b0, 1'b1, ex(8'd1, 1'b0, 1'b0, 1'b1),
          ex(8'd1, 1'b0, 1'b0, 1'b1), "sub4_3");
    step8(3'b010, 8'd3, 8'd8, 1'b0, 1'b1, ex(8'd251, 1'b1, 1'b1, 1'b1),
          ex(8'd0, 1'b1, 1'b1, 1'b1), "sub3_8");
    step8(3'b010, 8'd4, 8'd3, 1'b1, 1'b1, ex(8'd0, 1'b0, 1'b1, 1'b1),
          ex(8'd0, 1'b0, 1'b1, 1'b1), "sub4_3_rci");
    step8(3'b011, 8'd0, 8'd0, 1'b0, 1'b1, ex(8'd0, 1'b0, 1'b0, 1'b0),
          ex(8'd0, 1'b0, 1'b0, 1'b0), "clr2");

    // Back-to-back accumulate keeps VALID high.
    for (int i = 1; i <= 3; i++) begin
      step8(3'b100, 8'd5, 8'd0, 1'b0, 1'b1, ex(8'(5 * i), 1'b0, 1'b0, 1'b1),
            ex(8'(5 * i), 1'b0, 1'b0, 1'b1), $sformatf("acc5_%0d", i));
    end
    step8(3'b000, 8'd5, 8'd0, 1'b0, 1'b1, ex(8'd15, 1'b0, 1'b0, 1'b0),
          ex(8'd15, 1'b0, 1'b0, 1'b0), "hold");
    step8(3'b100, 8'd5, 8'd0, 1'b0, 1'b0, ex(8'd15, 1'b0, 1'b0, 1'b0),
          ex(8'd15, 1'b0, 1'b0, 1'b0), "acc_enb0");
    step8(3'b111, 8'd5, 8'd9, 1'b1, 1'b1, ex(8'd15, 1'b0, 1'b0, 1'b0),
          ex(8'd15, 1'b0, 1'b0, 1'b0), "reserved");
    step8(3'b101, 8'd20, 8'd0, 1'b0, 1'b1, ex(8'd251, 1'b1, 1'b1, 1'b1),
          ex(8'd0, 1'b1, 1'b1, 1'b1), "dacc20");
    step8(3'b011, 8'd0, 8'd0, 1'b0, 1'b1, ex(8'd0, 1'b0, 1'b0, 1'b0),
          ex(8'd0, 1'b0, 1'b0, 1'b0), "clr3");

    // Accumulate with carry-in, decrement with borrow-in, increment ignoring RCI.
    step8(3'b001, 8'd200, 8'd0, 1'b0, 1'b1, ex(8'd200, 1'b0, 1'b0, 1'b1),
          ex(8'd200, 1'b0, 1'b0, 1'b1), "load200");
    step8(3'b100, 8'd100, 8'd0, 1'b1, 1'b1, ex(8'd45, 1'b1, 1'b1, 1'b1),
          ex(8'd255, 1'b1, 1'b1, 1'b1), "acc100_rci");
    step8(3'b101, 8'd10, 8'd0, 1'b1, 1'b1, ex(8'd34, 1'b0, 1'b1, 1'b1),
          ex(8'd244, 1'b0, 1'b1, 1'b1), "dacc10_rci");
    step8(3'b110, 8'd77, 8'd0, 1'b1, 1'b1, ex(8'd35, 1'b0, 1'b1, 1'b1),
          ex(8'd245, 1'b0, 1'b1, 1'b1), "inc8");

    // Reset during a pending op discards it; next op starts from zero.
    @(negedge clk);
    modo8 = 3'b001; a8 = 8'd9; b8 = 8'd9; rci8 = 1'b0; enb8 = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midop_rst_w", actual(0), ex(8'd0, 1'b0, 1'b0, 1'b0));
    check("midop_rst_s", actual(1), ex(8'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    modo8 = 3'b000;
    step8(3'b100, 8'd7, 8'd0, 1'b0, 1'b1, ex(8'd7, 1'b0, 1'b0, 1'b1),
          ex(8'd7, 1'b0, 1'b0, 1'b1), "acc_after_rst");
    step8(3'b000, 8'd0, 8'd0, 1'b0, 1'b1, ex(8'd7, 1'b0, 1'b0, 1'b0),
          ex(8'd7, 1'b0, 1'b0, 1'b0), "hold2");

    // 4-bit increment wrap.
    step4(3'b011, 1'b0, ex(8'd0, 1'b0, 1'b0, 1'b0), "w4_clr");
    for (int i = 1; i <= 15; i++) begin
      step4(3'b110, 1'b1, ex(8'(i), 1'b0, 1'b0, 1'b1), $sformatf("w4_inc_%0d", i));
    end
    step4(3'b110, 1'b0, ex(8'd0, 1'b1, 1'b1, 1'b1), "w4_inc_wrap");
    step4(3'b000, 1'b0, ex(8'd0, 1'b1, 1'b1, 1'b0), "w4_hold");

    @(negedge clk);
    n_total++;
    if (sb.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
